box_arbiter: RTL and testbench

BOX_ARBITER -- requirements
Module: box_arbiter

---
 rtl/box_arb_pkg.sv | 33 +++
 rtl/box_arb_pick.sv | 20 ++
 rtl/box_arbiter.sv | 173 +++++++++++++++++
 tb/tb_box_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/box_arb_pkg.sv
// Shared types and default sizing for the two-port register-box arbiter.
package box_arb_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int ADDR_W_DEF     = 2;
    localparam int RD_TIMEOUT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One-hot winner {B, A}; b_first breaks the tie when both request.
    function automatic logic [1:0] pick_winner(input logic a_req,
                                               input logic b_req,
                                               input logic b_first);
        logic [1:0] win;
        win = 2'b00;
        if (a_req && b_req) begin
            win = b_first ? 2'b10 : 2'b01;
        end else if (a_req) begin
            win = 2'b01;
        end else if (b_req) begin
            win = 2'b10;
        end else begin
            win = 2'b00;
        end
        return win;
    endfunction

endpackage

// File: rtl/box_arb_pick.sv
// Winner selection between requesters A and B.
// BOX_ARB_FIXED_PRIO_EN: A always wins a tie and the round-robin pointer is ignored.
module box_arb_pick
    import box_arb_pkg::*;
(
    input  logic       i_a_req,
    input  logic       i_b_req,
    input  logic       i_ptr_b,
    output logic [1:0] o_win
);

`ifdef BOX_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = i_ptr_b;
    assign o_win        = pick_winner(i_a_req, i_b_req, 1'b0);
`else
    assign o_win        = pick_winner(i_a_req, i_b_req, i_ptr_b);
`endif

endmodule

// File: rtl/box_arbiter.sv
// Two-port arbiter serialising A/B read/write commands onto one register box.
// Tie-break policy selectable with BOX_ARB_FIXED_PRIO_EN (see box_arb_pick).
module box_arbiter
    import box_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic              o_a_gnt,
    output logic              o_a_done,
    output logic [DATA_W-1:0] o_a_rdata,
    output logic              o_b_gnt,
    output logic              o_b_done,
    output logic [DATA_W-1:0] o_b_rdata,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_box_read_enable,
    output logic              o_box_write_enable,
    output logic [ADDR_W-1:0] o_box_address,
    output logic [DATA_W-1:0] o_box_write_data,
    input  logic [DATA_W-1:0] i_box_read_data,
    input  logic              i_box_read_active
);

    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;

    state_t            r_state;
    logic              r_ptr_b;
    logic              r_win_b;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_a_gnt;
    logic              r_a_done;
    logic [DATA_W-1:0] r_a_rdata;
    logic              r_b_gnt;
    logic              r_b_done;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_err;
    logic              r_busy;
    logic              r_box_re;
    logic              r_box_we;
    logic [ADDR_W-1:0] r_box_addr;
    logic [DATA_W-1:0] r_box_wdata;

    logic [1:0]        w_win;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    box_arb_pick u_pick (
        .i_a_req (i_a_req),
        .i_b_req (i_b_req),
        .i_ptr_b (r_ptr_b),
        .o_win   (w_win)
    );

    assign w_sel_we    = w_win[1] ? i_b_we    : i_a_we;
    assign w_sel_addr  = w_win[1] ? i_b_addr  : i_a_addr;
    assign w_sel_wdata = w_win[1] ? i_b_wdata : i_a_wdata;

    // Arbiter FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr_b     <= 1'b0;
            r_win_b     <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= {CNT_W{1'b0}};
            r_a_gnt     <= 1'b0;
            r_a_done    <= 1'b0;
            r_a_rdata   <= {DATA_W{1'b0}};
            r_b_gnt     <= 1'b0;
            r_b_done    <= 1'b0;
            r_b_rdata   <= {DATA_W{1'b0}};
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_box_re    <= 1'b0;
            r_box_we    <= 1'b0;
            r_box_addr  <= {ADDR_W{1'b0}};
            r_box_wdata <= {DATA_W{1'b0}};
        end else begin
            r_a_gnt  <= 1'b0;
            r_b_gnt  <= 1'b0;
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_err    <= 1'b0;
            r_box_re <= 1'b0;
            r_box_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win != 2'b00) begin
                        r_state     <= ST_ISSUE;
                        r_busy      <= 1'b1;
                        r_win_b     <= w_win[1];
                        r_we        <= w_sel_we;
                        r_a_gnt     <= w_win[0];
                        r_b_gnt     <= w_win[1];
                        r_box_we    <= w_sel_we;
                        r_box_re    <= ~w_sel_we;
                        r_box_addr  <= w_sel_addr;
                        r_box_wdata <= w_sel_wdata;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (r_we) begin
                        r_state  <= ST_DONE;
                        r_a_done <= ~r_win_b;
                        r_b_done <= r_win_b;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response on the final wait cycle still counts as success.
                    if (i_box_read_active) begin
                        if (r_win_b) begin
                            r_b_rdata <= i_box_read_data;
                        end else begin
                            r_a_rdata <= i_box_read_data;
                        end
                        r_state  <= ST_DONE;
                        r_a_done <= ~r_win_b;
                        r_b_done <= r_win_b;
                    end else if (r_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                        r_state  <= ST_DONE;
                        r_a_done <= ~r_win_b;
                        r_b_done <= r_win_b;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ptr_b <= ~r_win_b;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_a_gnt            = r_a_gnt;
    assign o_a_done           = r_a_done;
    assign o_a_rdata          = r_a_rdata;
    assign o_b_gnt            = r_b_gnt;
    assign o_b_done           = r_b_done;
    assign o_b_rdata          = r_b_rdata;
    assign o_err              = r_err;
    assign o_busy             = r_busy;
    assign o_box_read_enable  = r_box_re;
    assign o_box_write_enable = r_box_we;
    assign o_box_address      = r_box_addr;
    assign o_box_write_data   = r_box_wdata;

endmodule

// File: tb/tb_box_arbiter.sv
// Self-checking bench for box_arbiter: per-scenario tasks plus a done-pulse scoreboard.
module tb_box_arbiter;

    localparam int RD_TO = 4;

    logic       clk, rst;
    logic       a_req, a_we, b_req, b_we;
    logic [1:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_done, b_gnt, b_done, err, busy;
    logic [7:0] a_rdata, b_rdata;
    logic       box_re, box_we;
    logic [1:0] box_addr;
    logic [7:0] box_wdata, box_rdata;
    logic       box_ract;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       port_b;
        logic       err;
        logic [7:0] rdata;
    } sb_item_t;

    sb_item_t   sb_q[$];
    sb_item_t   mon_it;
    logic [7:0] exp_a_rd, exp_b_rd;
    logic [7:0] mem [4];
    logic       rd_respond, pend;
    logic [1:0] pend_addr;

    box_arbiter #(.DATA_W(8), .ADDR_W(2), .RD_TIMEOUT(RD_TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_a_gnt(a_gnt), .o_a_done(a_done), .o_a_rdata(a_rdata),
        .o_b_gnt(b_gnt), .o_b_done(b_done), .o_b_rdata(b_rdata),
        .o_err(err), .o_busy(busy),
        .o_box_read_enable(box_re), .o_box_write_enable(box_we),
        .o_box_address(box_addr), .o_box_write_data(box_wdata),
        .i_box_read_data(box_rdata), .i_box_read_active(box_ract)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Register box model: stores writes, answers reads one cycle after the strobe when enabled.
    always @(negedge clk) begin
        if (box_we) mem[box_addr] = box_wdata;
        if (box_re && rd_respond) begin
            pend      = 1'b1;
            pend_addr = box_addr;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend) begin
            box_ract  = 1'b1;
            box_rdata = mem[pend_addr];
            pend      = 1'b0;
        end else begin
            box_ract  = 1'b0;
            box_rdata = 8'hEE;
        end
    end

    // Scoreboard: each done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_done || b_done) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_done a_done=%b b_done=%b", a_done, b_done);
                end else begin
                    mon_it = sb_q.pop_front();
                    if (b_done !== mon_it.port_b || a_done === b_done || err !== mon_it.err ||
                        (mon_it.port_b ? b_rdata : a_rdata) !== mon_it.rdata) begin
                        bad++;
                        $display("FAIL sb_done got a/b=%b%b err=%b rd=%h/%h need port_b=%b err=%b rd=%h",
                                 a_done, b_done, err, a_rdata, b_rdata,
                                 mon_it.port_b, mon_it.err, mon_it.rdata);
                    end
                end
            end
            if (box_re || box_we) begin
                total++;
                if (box_re && box_we) begin
                    bad++;
                    $display("FAIL strobe_excl re=%b we=%b need not both", box_re, box_we);
                end
            end
        end
    end

    task automatic drive_req(input logic pb, input logic v, input logic we,
                             input logic [1:0] ad, input logic [7:0] wd);
        if (pb) begin
            b_req = v; b_we = we; b_addr = ad; b_wdata = wd;
        end else begin
            a_req = v; a_we = we; a_addr = ad; a_wdata = wd;
        end
    endtask

    task automatic push_exp(input logic pb, input logic e, input logic [7:0] rd);
        sb_item_t it;
        it.port_b = pb; it.err = e; it.rdata = rd;
        sb_q.push_back(it);
    endtask

    // Single uncontended transaction with cycle-exact checks relative to the sampling edge.
    task automatic run_txn(input logic pb, input logic we, input logic [1:0] addr,
                           input logic [7:0] wd, input logic respond, input int done_cyc,
                           input logic exp_err, input logic [7:0] exp_rd, input string nm);
        logic w_gnt, w_done, l_gnt, l_done;
        push_exp(pb, exp_err, exp_rd);
        rd_respond = respond;
        @(posedge clk); #1;
        drive_req(pb, 1'b1, we, addr, wd);
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(posedge clk); #1;
            w_gnt  = pb ? b_gnt  : a_gnt;
            l_gnt  = pb ? a_gnt  : b_gnt;
            w_done = pb ? b_done : a_done;
            l_done = pb ? a_done : b_done;
            total++;
            if (w_gnt !== (c == 1) || l_gnt !== 1'b0) begin
                bad++;
                $display("FAIL %s_gnt cyc=%0d win=%b lose=%b need win=%b lose=0", nm, c, w_gnt, l_gnt, c == 1);
            end
            total++;
            if (w_done !== (c == done_cyc) || l_done !== 1'b0) begin
                bad++;
                $display("FAIL %s_done cyc=%0d win=%b lose=%b need win=%b lose=0", nm, c, w_done, l_done, c == done_cyc);
            end
            total++;
            if (busy !== (c <= done_cyc)) begin
                bad++;
                $display("FAIL %s_busy cyc=%0d got=%b need=%b", nm, c, busy, c <= done_cyc);
            end
            if (c == 1) begin
                total++;
                if (box_we !== we || box_re !== !we || box_addr !== addr || (we && box_wdata !== wd)) begin
                    bad++;
                    $display("FAIL %s_issue we=%b re=%b addr=%h data=%h need we=%b addr=%h data=%h",
                             nm, box_we, box_re, box_addr, box_wdata, we, addr, wd);
                end
                drive_req(pb, 1'b0, we, addr, wd);
            end else begin
                total++;
                if (box_we !== 1'b0 || box_re !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_strobe_idle cyc=%0d we=%b re=%b need 0", nm, c, box_we, box_re);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        total++;
        if ({a_gnt, b_gnt, a_done, b_done, err, busy, box_re, box_we,
             a_rdata, b_rdata, box_addr, box_wdata} !== 34'd0) begin
            bad++;
            $display("FAIL reset_outputs busy=%b rd=%h/%h addr=%h wd=%h need all 0",
                     busy, a_rdata, b_rdata, box_addr, box_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_a_rd = 8'h00;
        exp_b_rd = 8'h00;
    endtask

    // Simultaneous requests; A re-requests right after its own completion to test alternation.
    task automatic test_contention;
        logic exp_order[$];
        int   a_left, idx, cyc;
`ifdef BOX_ARB_FIXED_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b1};
        a_left    = 3;
`else
        exp_order = '{1'b0, 1'b1, 1'b0};
        a_left    = 2;
`endif
        foreach (exp_order[i]) push_exp(exp_order[i], 1'b0, 8'h00);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 1'b1, 2'd0, 8'h10);
        drive_req(1'b1, 1'b1, 1'b1, 2'd1, 8'h20);
        idx = 0;
        cyc = 0;
        while (idx < exp_order.size() && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (a_gnt || b_gnt) begin
                total++;
                if (b_gnt !== exp_order[idx] || (a_gnt && b_gnt)) begin
                    bad++;
                    $display("FAIL contention_order grant%0d a=%b b=%b need b=%b", idx, a_gnt, b_gnt, exp_order[idx]);
                end
                if (a_gnt) begin
                    a_req  = 1'b0;
                    a_left = a_left - 1;
                end
                if (b_gnt) b_req = 1'b0;
                idx++;
            end
            if (a_done && a_left > 0) begin
                a_req   = 1'b1;
                a_wdata = a_wdata + 8'h01;
            end
        end
        total++;
        if (idx != exp_order.size()) begin
            bad++;
            $display("FAIL contention_timeout grants=%0d need=%0d", idx, exp_order.size());
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        push_exp(1'b0, 1'b0, exp_a_rd);
        push_exp(1'b1, 1'b0, exp_b_rd);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 1'b1, 2'd1, 8'h11);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            total++;
            if (a_gnt !== (c == 1) || b_gnt !== (c == 4)) begin
                bad++;
                $display("FAIL b2b_gnt cyc=%0d a=%b b=%b need a=%b b=%b", c, a_gnt, b_gnt, c == 1, c == 4);
            end
            total++;
            if (a_done !== (c == 2) || b_done !== (c == 5)) begin
                bad++;
                $display("FAIL b2b_done cyc=%0d a=%b b=%b need a=%b b=%b", c, a_done, b_done, c == 2, c == 5);
            end
            if (c == 1) begin
                drive_req(1'b0, 1'b0, 1'b1, 2'd1, 8'h11);
                drive_req(1'b1, 1'b1, 1'b1, 2'd2, 8'h22);
            end
            if (c == 4) begin
                total++;
                if (box_we !== 1'b1 || box_addr !== 2'd2 || box_wdata !== 8'h22) begin
                    bad++;
                    $display("FAIL b2b_issue we=%b addr=%h data=%h need 1/2/22", box_we, box_addr, box_wdata);
                end
                drive_req(1'b1, 1'b0, 1'b1, 2'd2, 8'h22);
            end
        end
    endtask

    task automatic test_drop;
        push_exp(1'b1, 1'b0, exp_b_rd);
        @(posedge clk); #1;
        drive_req(1'b1, 1'b1, 1'b1, 2'd3, 8'h99);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                total++;
                if (b_gnt !== 1'b1) begin
                    bad++;
                    $display("FAIL drop_b_gnt got=%b need=1", b_gnt);
                end
                drive_req(1'b1, 1'b0, 1'b1, 2'd3, 8'h99);
                drive_req(1'b0, 1'b1, 1'b1, 2'd0, 8'h01);
            end else begin
                total++;
                if (a_gnt !== 1'b0 || a_done !== 1'b0) begin
                    bad++;
                    $display("FAIL drop_a_ignored cyc=%0d gnt=%b done=%b need 0/0", c, a_gnt, a_done);
                end
                if (c == 2) drive_req(1'b0, 1'b0, 1'b1, 2'd0, 8'h01);
            end
        end
    endtask

    task automatic test_reset_mid;
        rd_respond = 1'b0;
        @(posedge clk); #1;
        drive_req(1'b1, 1'b1, 1'b0, 2'd1, 8'h00);
        @(posedge clk); #1;
        drive_req(1'b1, 1'b0, 1'b0, 2'd1, 8'h00);
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_busy got=%b need=1", busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({a_gnt, b_gnt, a_done, b_done, err, busy, box_re, box_we,
             a_rdata, b_rdata, box_addr, box_wdata} !== 34'd0) begin
            bad++;
            $display("FAIL rstmid_outputs busy=%b rd=%h/%h done=%b%b need all 0",
                     busy, a_rdata, b_rdata, a_done, b_done);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        exp_a_rd = 8'h00;
        exp_b_rd = 8'h00;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            total++;
            if (a_done !== 1'b0 || b_done !== 1'b0 || busy !== 1'b0 || b_gnt !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_quiet cyc=%0d done=%b%b busy=%b need 0", c, a_done, b_done, busy);
            end
        end
    endtask

    initial begin
        a_req = 1'b0; a_we = 1'b0; a_addr = 2'd0; a_wdata = 8'h00;
        b_req = 1'b0; b_we = 1'b0; b_addr = 2'd0; b_wdata = 8'h00;
        box_ract = 1'b0; box_rdata = 8'h00;
        rd_respond = 1'b0; pend = 1'b0; pend_addr = 2'd0;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;

        test_reset();
        test_contention();
        run_txn(1'b0, 1'b1, 2'd0, 8'hAA, 1'b0, 2, 1'b0, exp_a_rd, "wr_a_aa");
        run_txn(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 3, 1'b0, 8'hAA, "rd_b_aa");
        exp_b_rd = 8'hAA;
        run_txn(1'b0, 1'b1, 2'd3, 8'h5C, 1'b0, 2, 1'b0, exp_a_rd, "wr_a_5c");
        run_txn(1'b1, 1'b1, 2'd2, 8'hC3, 1'b0, 2, 1'b0, exp_b_rd, "wr_b_c3");
        run_txn(1'b0, 1'b0, 2'd3, 8'h00, 1'b1, 3, 1'b0, 8'h5C, "rd_a_5c");
        exp_a_rd = 8'h5C;
        run_txn(1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 3, 1'b0, 8'hC3, "rd_b_c3");
        exp_b_rd = 8'hC3;
        run_txn(1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 2 + RD_TO, 1'b1, exp_a_rd, "rd_a_tmo");
        test_back_to_back();
        test_drop();
        test_reset_mid();
        run_txn(1'b0, 1'b1, 2'd0, 8'h77, 1'b0, 2, 1'b0, exp_a_rd, "wr_a_post");
        run_txn(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 3, 1'b0, 8'h77, "rd_b_post");
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover pending=%0d need=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
